// File: rtl/debounce_pkg.sv
// Shared types and helpers for the button debouncer: FSM state encoding and
// the state-to-output decode used for the registered level/bouncing flags.
package debounce_pkg;

   typedef enum logic [1:0] {
      LOW       = 2'd0,
      RISE_WAIT = 2'd1,
      HIGH      = 2'd2,
      FALL_WAIT = 2'd3
   } dbnc_state_t;

   // Debounced level is high in HIGH and while a fall is still being qualified.
   function automatic logic state_level(input dbnc_state_t s);
      return (s == HIGH) || (s == FALL_WAIT);
   endfunction

   function automatic logic state_bouncing(input dbnc_state_t s);
      return (s == RISE_WAIT) || (s == FALL_WAIT);
   endfunction

endpackage

// File: rtl/debounce_timer.sv
// Saturating up-counter with async active-low reset, synchronous clear and
// count enable. Clear together with enable restarts the count at 1.
module debounce_timer #(
   parameter int unsigned MAX   = 8,
   parameter int unsigned WIDTH = $clog2(MAX + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] cnt_o
);

   localparam logic [WIDTH-1:0] CntMax = WIDTH'(MAX);

   logic [WIDTH-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = en_i ? WIDTH'(1) : '0;
      end else if (en_i && (cnt_q != CntMax)) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/button_debouncer.sv
// Button debouncer: qualifies level changes over STABLE_CYCLES samples and
// emits registered press/release/long-press pulses plus a bouncing flag.
module button_debouncer
   import debounce_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 8,
   parameter int unsigned HOLD_CYCLES   = 64
) (
   input  logic clock,
   input  logic reset_L,
   input  logic en,
   input  logic sync_in,
   output logic level,
   output logic pressed,
   output logic released,
   output logic held,
   output logic bouncing
);

   localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
   localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);

   // Count values seen on the edge that completes qualification / the hold time.
   localparam logic [SW-1:0] StableLast = SW'(STABLE_CYCLES - 1);
   localparam logic [HW-1:0] HoldLast   = HW'(HOLD_CYCLES - 1);

   dbnc_state_t state_d, state_q;
   logic        level_d, level_q;
   logic        pressed_d, pressed_q;
   logic        released_d, released_q;
   logic        held_d, held_q;
   logic        bouncing_d, bouncing_q;

   logic          stab_clr, stab_inc;
   logic          hold_clr, hold_inc;
   logic          rise_done, fall_done;
   logic [SW-1:0] stab_cnt;
   logic [HW-1:0] hold_cnt;

   debounce_timer #(
      .MAX   (STABLE_CYCLES),
      .WIDTH (SW)
   ) u_stable_timer (
      .clk_i  (clock),
      .rst_ni (reset_L),
      .clr_i  (stab_clr),
      .en_i   (stab_inc),
      .cnt_o  (stab_cnt)
   );

   debounce_timer #(
      .MAX   (HOLD_CYCLES),
      .WIDTH (HW)
   ) u_hold_timer (
      .clk_i  (clock),
      .rst_ni (reset_L),
      .clr_i  (hold_clr),
      .en_i   (hold_inc),
      .cnt_o  (hold_cnt)
   );

   always_comb begin
      state_d    = state_q;
      level_d    = level_q;
      bouncing_d = bouncing_q;
      pressed_d  = 1'b0;
      released_d = 1'b0;
      held_d     = 1'b0;
      stab_clr   = 1'b0;
      stab_inc   = 1'b0;
      hold_clr   = 1'b0;
      hold_inc   = 1'b0;
      rise_done  = 1'b0;
      fall_done  = 1'b0;

      if (en) begin
         unique case (state_q)
            LOW: begin
               // Clear-with-increment loads 1 for the first qualifying sample.
               stab_clr = 1'b1;
               stab_inc = sync_in;
               if (sync_in) begin
                  state_d = RISE_WAIT;
               end
            end
            RISE_WAIT: begin
               if (!sync_in) begin
                  state_d  = LOW;
                  stab_clr = 1'b1;
               end else if (stab_cnt == StableLast) begin
                  state_d   = HIGH;
                  stab_clr  = 1'b1;
                  rise_done = 1'b1;
               end else begin
                  stab_inc = 1'b1;
               end
            end
            HIGH: begin
               stab_clr = 1'b1;
               stab_inc = !sync_in;
               if (!sync_in) begin
                  state_d = FALL_WAIT;
               end
            end
            FALL_WAIT: begin
               if (sync_in) begin
                  state_d  = HIGH;
                  stab_clr = 1'b1;
               end else if (stab_cnt == StableLast) begin
                  state_d   = LOW;
                  stab_clr  = 1'b1;
                  fall_done = 1'b1;
               end else begin
                  stab_inc = 1'b1;
               end
            end
         endcase

         hold_clr   = rise_done;
         hold_inc   = level_q;
         level_d    = state_level(state_d);
         bouncing_d = state_bouncing(state_d);
         pressed_d  = rise_done;
         released_d = fall_done;
         // A release on the same edge the hold time completes wins over held.
         held_d     = level_q && (hold_cnt == HoldLast) && !fall_done;
      end
   end

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         state_q    <= LOW;
         level_q    <= 1'b0;
         pressed_q  <= 1'b0;
         released_q <= 1'b0;
         held_q     <= 1'b0;
         bouncing_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         level_q    <= level_d;
         pressed_q  <= pressed_d;
         released_q <= released_d;
         held_q     <= held_d;
         bouncing_q <= bouncing_d;
      end
   end

   assign level    = level_q;
   assign pressed  = pressed_q;
   assign released = released_q;
   assign held     = held_q;
   assign bouncing = bouncing_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed, table-driven bench for button_debouncer with STABLE_CYCLES=4 and
// HOLD_CYCLES=16; outputs are compared as {level,pressed,released,held,bouncing}.
module tb_button_debouncer;

   localparam int unsigned StableCycles = 4;
   localparam int unsigned HoldCycles   = 16;

   logic clock;
   logic reset_L;
   logic en;
   logic sync_in;
   logic level;
   logic pressed;
   logic released;
   logic held;
   logic bouncing;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic       en;
      logic       din;
      logic [4:0] exp;
      string      tag;
   } vec_t;

   vec_t vecs[$];

   button_debouncer #(
      .STABLE_CYCLES (StableCycles),
      .HOLD_CYCLES   (HoldCycles)
   ) dut (
      .clock    (clock),
      .reset_L  (reset_L),
      .en       (en),
      .sync_in  (sync_in),
      .level    (level),
      .pressed  (pressed),
      .released (released),
      .held     (held),
      .bouncing (bouncing)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic logic [4:0] outs();
      return {level, pressed, released, held, bouncing};
   endfunction

   task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %b, required %b (lvl,prs,rel,hld,bnc)", name, got, exp);
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, required %0d", name, got, exp);
   endtask

   task automatic add(input logic e, input logic d, input logic [4:0] x, input string t);
      vec_t v;
      v.en  = e;
      v.din = d;
      v.exp = x;
      v.tag = t;
      vecs.push_back(v);
   endtask

   task automatic step(input logic e, input logic d);
      en      = e;
      sync_in = d;
      @(posedge clock);
      #1;
   endtask

   // Reset asserted and released between clock edges.
   task automatic do_reset();
      reset_L = 1'b0;
      sync_in = 1'b0;
      en      = 1'b1;
      #2;
      check("reset_state", outs(), 5'b00000);
      #2;
      reset_L = 1'b1;
   endtask

   initial begin
      int held_n;
      int held_at;
      int rel_n;

      reset_L = 1'b0;
      en      = 1'b1;
      sync_in = 1'b0;

      // Basic press / release.
      for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 5'b00001, "rise_qual");
      add(1'b1, 1'b1, 5'b11000, "press");
      add(1'b1, 1'b1, 5'b10000, "press_one_cycle");
      for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 5'b10001, "fall_qual");
      add(1'b1, 1'b0, 5'b00100, "release");
      add(1'b1, 1'b0, 5'b00000, "release_one_cycle");
      // Glitch during rise: 1,1,1,0,1,1,1,1.
      for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 5'b00001, "glitch_run1");
      add(1'b1, 1'b0, 5'b00000, "glitch_drop");
      for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 5'b00001, "glitch_run2");
      add(1'b1, 1'b1, 5'b11000, "glitch_press");
      // Glitch during fall: 0,0,0,1 then 0 x4.
      for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 5'b10001, "fall_glitch_run");
      add(1'b1, 1'b1, 5'b10000, "fall_glitch_back_high");
      for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 5'b10001, "fall_run2");
      add(1'b1, 1'b0, 5'b00100, "fall_release");
      add(1'b1, 1'b0, 5'b00000, "fall_idle");

      do_reset();
      foreach (vecs[i]) begin
         step(vecs[i].en, vecs[i].din);
         check($sformatf("%s[%0d]", vecs[i].tag, i), outs(), vecs[i].exp);
      end

      // Long press: held once, HoldCycles cycles after pressed.
      do_reset();
      repeat (StableCycles) step(1'b1, 1'b1);
      check("long_press_pressed", outs(), 5'b11000);
      held_n  = 0;
      held_at = -1;
      for (int i = 1; i <= 40; i++) begin
         step(1'b1, 1'b1);
         if (held) begin
            held_n++;
            if (held_at < 0) held_at = i;
         end
      end
      check_int("held_count", held_n, 1);
      check_int("held_delay", held_at, int'(HoldCycles));

      // Release landing on the hold-completion edge suppresses held.
      do_reset();
      repeat (StableCycles) step(1'b1, 1'b1);
      repeat (12) step(1'b1, 1'b1);
      repeat (3) step(1'b1, 1'b0);
      check("pre_suppress", outs(), 5'b10001);
      step(1'b1, 1'b0);
      check("held_suppressed", outs(), 5'b00100);
      held_n = 0;
      repeat (5) begin
         step(1'b1, 1'b0);
         if (held) held_n++;
      end
      check_int("no_late_held", held_n, 0);

      // Enable freeze mid-qualification.
      do_reset();
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      check("pre_freeze", outs(), 5'b00001);
      for (int i = 0; i < 10; i++) begin
         step(1'b0, (i % 2) == 1);
         check($sformatf("freeze[%0d]", i), outs(), 5'b00001);
      end
      step(1'b1, 1'b1);
      check("resume_1", outs(), 5'b00001);
      step(1'b1, 1'b1);
      check("resume_press", outs(), 5'b11000);

      // Async reset while HIGH.
      do_reset();
      repeat (StableCycles + 3) step(1'b1, 1'b1);
      check("in_high", outs(), 5'b10000);
      #2 reset_L = 1'b0;
      #1 check("async_reset_high", outs(), 5'b00000);
      #2 reset_L = 1'b1;
      rel_n = 0;
      repeat (6) begin
         step(1'b1, 1'b0);
         if (released || level) rel_n++;
      end
      check_int("no_release_after_reset", rel_n, 0);
      step(1'b1, 1'b1);
      check("fresh_low_sample", outs(), 5'b00001);

      // Async reset while FALL_WAIT.
      do_reset();
      repeat (StableCycles + 1) step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      check("in_fall_wait", outs(), 5'b10001);
      #2 reset_L = 1'b0;
      #1 check("async_reset_fall", outs(), 5'b00000);
      #2 reset_L = 1'b1;
      rel_n = 0;
      repeat (6) begin
         step(1'b1, 1'b0);
         if (released) rel_n++;
      end
      check_int("no_release_from_fall_wait", rel_n, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
